// File: rtl/slice_rr_arbiter.sv
// slice_rr_arbiter
//   Round-robin time-sliced arbiter for one shared slotted resource. Each grant lasts until the
//   owner releases its request or the slot counter reaches SLICE_LEN-1. Every grant is followed
//   by exactly one dead (handover) cycle.
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_enable     global advance enable; low freezes all state
//   i_req        level requests, bit k = requester k
//   o_grant      registered one-hot grant, or all zero
//   o_owner      index of current or last owner
//   o_slot_cnt   slot index inside the current slice
//   o_busy       high while a grant is active
//   o_slice_end  one-cycle pulse: slice expired while the owner still requested
module slice_rr_arbiter #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned SLICE_LEN = 25,
   parameter int unsigned CNT_W     = 5
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_enable,
   input  logic [N_REQ-1:0]           i_req,
   output logic [N_REQ-1:0]           o_grant,
   output logic [$clog2(N_REQ)-1:0]   o_owner,
   output logic [CNT_W-1:0]           o_slot_cnt,
   output logic                       o_busy,
   output logic                       o_slice_end
);

   localparam int unsigned OWN_W = $clog2(N_REQ);
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLICE_LEN - 1);
   localparam logic [OWN_W-1:0] LAST_REQ  = OWN_W'(N_REQ - 1);

   typedef enum logic [1:0] {StIdle, StGrant, StHandover} state_e;

   state_e             state_q, state_d;
   logic [OWN_W-1:0]   owner_q, owner_d;
   logic [OWN_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   slot_q, slot_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic               busy_q, busy_d;
   logic               slice_end_q, slice_end_d;

   logic [OWN_W-1:0]   win_idx;
   logic               win_found;
   int unsigned        scan_idx;
   logic [OWN_W-1:0]   ptr_next;
   logic [N_REQ-1:0]   win_onehot;

   // Round-robin pick: first set request scanning ptr, ptr+1, ... modulo N_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         scan_idx = (int'(ptr_q) + i) % N_REQ;
         if (!win_found && i_req[OWN_W'(scan_idx)]) begin
            win_found = 1'b1;
            win_idx   = OWN_W'(scan_idx);
         end
      end
   end

   assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
   assign ptr_next   = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      slot_d      = slot_q;
      grant_d     = grant_q;
      busy_d      = busy_q;
      slice_end_d = slice_end_q;
      if (i_enable) begin
         slice_end_d = 1'b0;
         unique case (state_q)
            StIdle, StHandover: begin
               if (win_found) begin
                  state_d = StGrant;
                  owner_d = win_idx;
                  grant_d = win_onehot;
                  busy_d  = 1'b1;
                  slot_d  = '0;
               end else begin
                  state_d = StIdle;
               end
            end
            StGrant: begin
               if (!i_req[owner_q] || (slot_q == LAST_SLOT)) begin
                  state_d     = StHandover;
                  // Release wins over expiry: only a still-held request flags slice end.
                  slice_end_d = i_req[owner_q];
                  ptr_d       = ptr_next;
                  slot_d      = '0;
                  grant_d     = '0;
                  busy_d      = 1'b0;
               end else begin
                  slot_d = slot_q + 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               grant_d = '0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         owner_q     <= '0;
         ptr_q       <= '0;
         slot_q      <= '0;
         grant_q     <= '0;
         busy_q      <= 1'b0;
         slice_end_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         ptr_q       <= ptr_d;
         slot_q      <= slot_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         slice_end_q <= slice_end_d;
      end
   end

   assign o_grant     = grant_q;
   assign o_owner     = owner_q;
   assign o_slot_cnt  = slot_q;
   assign o_busy      = busy_q;
   // The pulse register freezes with everything else; the output is masked while disabled.
   assign o_slice_end = slice_end_q & i_enable;

endmodule

// File: tb/tb_slice_rr_arbiter.sv
// tb_slice_rr_arbiter
//   Directed bench for slice_rr_arbiter. Stimulus pushes one expected record per grant episode;
//   a monitor pops a record when a grant starts and checks its shape while it runs and ends.
module tb_slice_rr_arbiter;

   localparam int N_REQ     = 4;
   localparam int SLICE_LEN = 25;
   localparam int CNT_W     = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [1:0]       owner;
   logic [CNT_W-1:0] slot_cnt;
   logic             busy;
   logic             slice_end;

   slice_rr_arbiter #(
      .N_REQ     (N_REQ),
      .SLICE_LEN (SLICE_LEN),
      .CNT_W     (CNT_W)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_enable    (enable),
      .i_req       (req),
      .o_grant     (grant),
      .o_owner     (owner),
      .o_slot_cnt  (slot_cnt),
      .o_busy      (busy),
      .o_slice_end (slice_end)
   );

   always #5 clk = ~clk;

   // len = enabled grant cycles (0: episode aborted by reset); gap = idle cycles before (-1: any)
   typedef struct {
      logic [3:0] grant;
      int         owner;
      int         len;
      bit         slice_end;
      int         gap;
   } rec_t;

   rec_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic void check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   task automatic push(input logic [3:0] g, input int own, input int len, input bit se,
                       input int gap);
      rec_t r;
      r.grant     = g;
      r.owner     = own;
      r.len       = len;
      r.slice_end = se;
      r.gap       = gap;
      exp_q.push_back(r);
   endtask

   // Stimulus acts 1 time unit after the falling edge; the monitor samples 3 units after it.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_slot(input int v, input string nm);
      int n   = 0;
      bit hit = 1'b0;
      while (!hit && n < 200) begin
         tick();
         n++;
         if (busy && int'(slot_cnt) == v) hit = 1'b1;
      end
      if (!hit) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout_%s: slot %0d not reached within 200 cycles", nm, v);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Monitor
   bit   mon_prev_busy = 1'b0;
   bit   mon_have      = 1'b0;
   int   mon_len       = 0;
   int   mon_gap       = 0;
   rec_t mon_cur;

   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (busy && !mon_prev_busy) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_grant: got grant %b, expected none", grant);
               mon_have = 1'b0;
            end else begin
               mon_cur  = exp_q.pop_front();
               mon_have = 1'b1;
               check("start_grant", int'(grant), int'(mon_cur.grant));
               check("start_owner", int'(owner), mon_cur.owner);
               check("start_slot", int'(slot_cnt), 0);
               if (mon_cur.gap >= 0) check("gap_cycles", mon_gap, mon_cur.gap);
            end
            mon_len = 0;
         end
         if (busy) begin
            if (mon_have) begin
               check("hold_grant", int'(grant), int'(mon_cur.grant));
               check("slot_seq", int'(slot_cnt), mon_len);
            end
            if (enable) mon_len++;
            mon_gap = 0;
         end else begin
            if (mon_prev_busy && mon_have) begin
               check("end_grant_zero", int'(grant), 0);
               if (mon_cur.len > 0) begin
                  check("grant_len", mon_len, mon_cur.len);
                  check("slice_end", int'(slice_end), int'(mon_cur.slice_end));
                  check("owner_kept", int'(owner), mon_cur.owner);
               end
               mon_have = 1'b0;
            end
            mon_gap++;
         end
         mon_prev_busy = busy;
      end
   end

   // Stimulus
   initial begin
      rst_n  = 1'b0;
      enable = 1'b1;
      req    = '0;
      #1;
      check("rst_grant", int'(grant), 0);
      check("rst_owner", int'(owner), 0);
      check("rst_slot", int'(slot_cnt), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_slice_end", int'(slice_end), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1: sole requester 2, full slice, one-cycle gap with slice_end, re-grant
      push(4'b0100, 2, 25, 1'b1, -1);
      push(4'b0100, 2, 4, 1'b0, 1);
      req = 4'b0100;
      tick();
      check("t1_first_grant", int'(grant), 4'b0100);
      wait_slot(24, "t1_a");
      wait_slot(3, "t1_b");
      req = '0;
      repeat (3) tick();

      // 2: all requesting, rotation 0,1,2,3,0
      do_reset();
      push(4'b0001, 0, 25, 1'b1, -1);
      push(4'b0010, 1, 25, 1'b1, 1);
      push(4'b0100, 2, 25, 1'b1, 1);
      push(4'b1000, 3, 25, 1'b1, 1);
      push(4'b0001, 0, 5, 1'b0, 1);
      req = 4'b1111;
      for (int i = 0; i < 4; i++) wait_slot(24, "t2_slice");
      wait_slot(4, "t2_end");
      req = '0;
      repeat (3) tick();

      // 3: owner 1 releases at slot 7; search resumes at 2 so requester 3 beats 0
      do_reset();
      push(4'b0010, 1, 8, 1'b0, -1);
      push(4'b1000, 3, 25, 1'b1, 1);
      push(4'b0001, 0, 3, 1'b0, 1);
      req = 4'b0010;
      wait_slot(0, "t3_start");
      req = 4'b1011;
      wait_slot(7, "t3_rel");
      req = 4'b1001;
      wait_slot(24, "t3_own3");
      wait_slot(2, "t3_end");
      req = '0;
      repeat (3) tick();

      // 4: enable low for 10 cycles at slot 12
      do_reset();
      push(4'b0001, 0, 25, 1'b1, -1);
      push(4'b0001, 0, 2, 1'b0, 1);
      req = 4'b0001;
      wait_slot(12, "t4_frz");
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t4_frozen_slot", int'(slot_cnt), 12);
         check("t4_frozen_grant", int'(grant), 4'b0001);
      end
      enable = 1'b1;
      tick();
      check("t4_resume_slot", int'(slot_cnt), 13);
      wait_slot(24, "t4_last");
      wait_slot(1, "t4_end");
      req = '0;
      repeat (3) tick();

      // 5: release exactly on the last slot -> no slice_end
      do_reset();
      push(4'b1000, 3, 25, 1'b0, -1);
      req = 4'b1000;
      wait_slot(24, "t5_last");
      req = '0;
      tick();
      check("t5_no_slice_end", int'(slice_end), 0);
      check("t5_busy_low", int'(busy), 0);
      repeat (3) tick();

      // 6: asynchronous reset mid-grant, then restart from requester 0's side
      do_reset();
      push(4'b0100, 2, 0, 1'b0, -1);
      req = 4'b0100;
      wait_slot(5, "t6_mid");
      rst_n = 1'b0;
      #1;
      check("t6_async_grant", int'(grant), 0);
      check("t6_async_busy", int'(busy), 0);
      check("t6_async_slot", int'(slot_cnt), 0);
      tick();
      push(4'b0010, 1, 3, 1'b0, -1);
      rst_n = 1'b1;
      req   = 4'b1010;
      wait_slot(2, "t6_end");
      req = '0;
      repeat (5) tick();

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
